// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch vs. data access to one unified memory.
// Data-first priority with alternation on contention, one transaction in flight.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_valid,
   output logic                    if_stall,
   input  logic                    dm_req,
   input  logic                    dm_we,
   input  logic [ADDR_WIDTH-1:0]   dm_addr,
   input  logic [DATA_WIDTH-1:0]   dm_wdata,
   input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
   output logic [DATA_WIDTH-1:0]   dm_rdata,
   output logic                    dm_valid,
   output logic                    dm_stall,
   output logic                    err,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic                    mem_ready,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state_q;
   logic                  owner_dm_q;
   logic                  last_dm_q;
   logic [CW-1:0]         cnt_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [SW-1:0]         mem_wstrb_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] dm_rdata_q;
   logic                  if_valid_q;
   logic                  dm_valid_q;
   logic                  err_q;
   logic                  grant_dm_d;

   // Data wins unless fetch is also waiting and data owned the last grant.
   always_comb begin
      grant_dm_d = dm_req & (~if_req | ~last_dm_q);
   end

   // Transaction sequencer: grant, issue, wait for response, report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_dm_q  <= 1'b0;
         last_dm_q   <= 1'b0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (dm_req || if_req) begin
                  state_q    <= S_ISSUE;
                  mem_req_q  <= 1'b1;
                  owner_dm_q <= grant_dm_d;
                  last_dm_q  <= grant_dm_d;
                  if (grant_dm_d) begin
                     mem_we_q    <= dm_we;
                     mem_addr_q  <= dm_addr;
                     mem_wdata_q <= dm_wdata;
                     mem_wstrb_q <= dm_wstrb;
                  end else begin
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr;
                     mem_wdata_q <= '0;
                     mem_wstrb_q <= '0;
                  end
               end
            end
            S_ISSUE: begin
               if (mem_ready) begin
                  mem_req_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  state_q <= S_RESP;
                  if (owner_dm_q) begin
                     dm_valid_q <= 1'b1;
                     dm_rdata_q <= mem_we_q ? '0 : mem_rdata;
                  end else begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= mem_rdata;
                  end
               end else if (cnt_q == CW'(TIMEOUT)) begin
                  state_q <= S_RESP;
                  err_q   <= 1'b1;
                  if (owner_dm_q) begin
                     dm_valid_q <= 1'b1;
                     dm_rdata_q <= '0;
                  end else begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RESP: begin
               if_valid_q <= 1'b0;
               dm_valid_q <= 1'b0;
               err_q      <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
   assign err       = err_q;
   assign if_stall  = if_req & ~if_valid_q;
   assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and memory,
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int T  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          if_stall;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [SW-1:0] dm_wstrb = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_valid;
   logic          dm_stall;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wstrb;
   logic          mem_ready = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT(T)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_rdata(if_rdata),
      .if_valid(if_valid),
      .if_stall(if_stall),
      .dm_req(dm_req),
      .dm_we(dm_we),
      .dm_addr(dm_addr),
      .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb),
      .dm_rdata(dm_rdata),
      .dm_valid(dm_valid),
      .dm_stall(dm_stall),
      .err(err),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   // transaction in flight, described by its event timestamps
   bit tr_act = 0;
   bit tr_dm = 0;
   bit tr_st = 0;
   bit tr_err = 0;
   int tr_acc = -1;
   int tr_done = -1;
   bit last_dm = 0;

   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0;
   logic [SW-1:0] e_wstrb = '0;
   logic          e_we = 1'b0;
   logic [DW-1:0] e_ifr = '0;
   logic [DW-1:0] e_dmr = '0;

   bit if_hold = 0;
   bit dm_hold = 0;
   bit if_fin = 0;
   bit dm_fin = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_mem_wstrb"}, mem_wstrb, 0);
      check({tag, "_if_rdata"}, if_rdata, 0);
      check({tag, "_dm_rdata"}, dm_rdata, 0);
      check({tag, "_if_valid"}, if_valid, 0);
      check({tag, "_dm_valid"}, dm_valid, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_if_stall"}, if_stall, 0);
      check({tag, "_dm_stall"}, dm_stall, 0);
   endtask

   task automatic model_reset();
      tr_act = 0;
      last_dm = 0;
      e_addr = '0;
      e_wdata = '0;
      e_wstrb = '0;
      e_we = 1'b0;
      e_ifr = '0;
      e_dmr = '0;
      if_hold = 0;
      dm_hold = 0;
      if_fin = 0;
      dm_fin = 0;
   endtask

   task automatic step();
      bit xm;
      bit xi;
      bit xd;
      bit xe;
      @(posedge clk);
      #1;
      cyc++;
      if (if_fin) if_hold = 0;
      if (dm_fin) dm_hold = 0;
      if_fin = 0;
      dm_fin = 0;
      if (!if_hold && $urandom_range(0, 2) == 0) begin
         if_hold = 1;
         if_addr = $urandom;
      end
      if (!dm_hold && $urandom_range(0, 2) == 0) begin
         dm_hold = 1;
         dm_we = 1'($urandom_range(0, 1));
         dm_addr = $urandom;
         dm_wdata = $urandom;
         dm_wstrb = 4'($urandom_range(0, 15));
      end
      if_req = if_hold;
      dm_req = dm_hold;
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      #1;
      xm = tr_act && tr_acc < 0;
      xi = tr_act && tr_done == cyc && !tr_dm;
      xd = tr_act && tr_done == cyc && tr_dm;
      xe = tr_act && tr_done == cyc && tr_err;
      check("mem_req", mem_req, xm);
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", mem_we, e_we);
      check("mem_wdata", mem_wdata, e_wdata);
      check("mem_wstrb", mem_wstrb, e_wstrb);
      check("if_valid", if_valid, xi);
      check("dm_valid", dm_valid, xd);
      check("err", err, xe);
      check("if_rdata", if_rdata, e_ifr);
      check("dm_rdata", dm_rdata, e_dmr);
      check("if_stall", if_stall, if_req && !xi);
      check("dm_stall", dm_stall, dm_req && !xd);
      if (tr_act && tr_done == cyc) begin
         tr_act = 0;
         if (tr_dm) dm_fin = 1;
         else if_fin = 1;
      end else if (!tr_act) begin
         if (dm_req || if_req) begin
            tr_act = 1;
            tr_acc = -1;
            tr_done = -1;
            tr_err = 0;
            tr_dm = dm_req && !(if_req && last_dm);
            last_dm = tr_dm;
            tr_st = tr_dm && dm_we;
            e_addr = tr_dm ? dm_addr : if_addr;
            e_we = tr_st;
            e_wdata = tr_dm ? dm_wdata : '0;
            e_wstrb = tr_dm ? dm_wstrb : '0;
         end
      end else if (tr_acc < 0) begin
         if (mem_ready) tr_acc = cyc;
      end else if (tr_done < 0) begin
         if (mem_rvalid) begin
            tr_done = cyc + 1;
            if (tr_dm) e_dmr = tr_st ? '0 : mem_rdata;
            else e_ifr = mem_rdata;
         end else if (cyc - tr_acc - 1 == T) begin
            tr_done = cyc + 1;
            tr_err = 1;
            if (tr_dm) e_dmr = '0;
            else e_ifr = '0;
         end
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      #2;
      check_zero("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (300) step();
      n = 0;
      while (!(tr_act && tr_acc >= 0 && tr_done < 0) && n < 200) begin
         step();
         n++;
      end
      check("reach_wait", (tr_act && tr_acc >= 0 && tr_done < 0), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      if_req = 1'b0;
      dm_req = 1'b0;
      mem_ready = 1'b1;
      mem_rvalid = 1'b1;
      #1;
      check_zero("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
         check("stray_if_valid", if_valid, 0);
         check("stray_dm_valid", dm_valid, 0);
         check("stray_mem_req", mem_req, 0);
         check("stray_err", err, 0);
      end
      repeat (300) step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
